// File: rtl/cnn_axi_mst.sv
// cnn_axi_mst: AXI3 single-burst initiator (command -> AR/R or AW/W/B); define CNN_AXI_MST_TIMEOUT_EN for a 16-bit stall watchdog
module cnn_axi_mst #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int ID_MAX_WIDTH = 12,
  parameter int MST_ID       = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [3:0]              cmd_len,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ID_MAX_WIDTH-1:0] arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arbrust,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_MAX_WIDTH-1:0] rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    ruser,
  input  logic                    rvalid,
  output logic                    rready,
  output logic [ID_MAX_WIDTH-1:0] awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awbrust,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ID_MAX_WIDTH-1:0] wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_MAX_WIDTH-1:0] bid,
  input  logic [1:0]              bresp,
  input  logic                    buser,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic [3:0]              arqos,
  output logic [3:0]              arregion,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic [3:0]              awqos
);
  localparam logic [ID_MAX_WIDTH-1:0] ID = ID_MAX_WIDTH'(MST_ID);
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH/8));
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0] len_q, cnt;
  logic [1:0] acc;
  logic start, arhs, awhs, rbeat, wbeat, bbeat, hs, tmo, unused;
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return a > b ? a : b;
  endfunction
  assign unused = ^{ruser, buser};
  assign {arid, awid, wid} = {ID, ID, ID};
  assign {araddr, awaddr, arlen, awlen} = {addr_q, addr_q, len_q, len_q};
  assign {arsize, awsize, arbrust, awbrust} = {SIZE, SIZE, 2'b01, 2'b01};
  assign wstrb = '1;
  assign wdata = wd_data;
  assign {arlock, arcache, arprot, arqos, arregion} = '0;
  assign {awlock, awcache, awprot, awqos} = '0;
  assign start = state == IDLE && cmd_valid && cmd_ready;
  assign arhs  = !tmo && state == RD_ADDR && arready;
  assign awhs  = !tmo && state == WR_ADDR && awready;
  assign rbeat = !tmo && state == RD_DATA && rvalid;
  assign wbeat = !tmo && state == WR_DATA && wd_valid && wready;
  assign bbeat = !tmo && state == WR_RESP && bvalid;
  assign hs    = arhs || awhs || rbeat || wbeat || bbeat;
`ifdef CNN_AXI_MST_TIMEOUT_EN
  logic [15:0] wdog;
  assign tmo = wdog == 16'hFFFF;
  // stall watchdog: cleared by any handshake or outside an active burst
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wdog <= '0;
    else wdog <= (state == IDLE || state == DONE || hs) ? '0 : wdog + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state and channel handshake outputs; a watchdog expiry drops everything and ends the command
  always_comb begin
    nxt = state;
    {arvalid, rready, awvalid, wvalid, wd_ready, wlast, bready, done} = '0;
    done_resp = 2'b00;
    case (state)
      IDLE:    nxt = start ? (cmd_wr ? WR_ADDR : RD_ADDR) : IDLE;
      RD_ADDR: begin arvalid = !tmo; nxt = arhs ? RD_DATA : RD_ADDR; end
      RD_DATA: begin rready = !tmo; nxt = rbeat && rlast ? DONE : RD_DATA; end
      WR_ADDR: begin awvalid = !tmo; nxt = awhs ? WR_DATA : WR_ADDR; end
      WR_DATA: begin
        wvalid = wd_valid && !tmo;
        wd_ready = wready && !tmo;
        wlast = cnt == len_q;
        nxt = wbeat && wlast ? WR_RESP : WR_DATA;
      end
      WR_RESP: begin bready = !tmo; nxt = bbeat ? DONE : WR_RESP; end
      DONE:    begin done = 1'b1; done_resp = acc; nxt = IDLE; end
      default: nxt = IDLE;
    endcase
    nxt = tmo ? DONE : nxt;
  end
  // command latch, beat counter, worst-response accumulator and registered read stream
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {cmd_ready, addr_q, len_q, cnt, acc} <= '0;
      {rd_data, rd_valid, rd_last} <= '0;
    end else begin
      cmd_ready <= nxt == IDLE;
      rd_valid <= rbeat;
      rd_last <= rbeat && rlast;
      if (rbeat) rd_data <= rdata;
      if (start) {addr_q, len_q} <= {cmd_addr, cmd_len};
      cnt <= start ? 4'd0 : (rbeat || wbeat) ? cnt + 4'd1 : cnt;
      if (start) acc <= 2'b00;
      else if (tmo) acc <= 2'b11;
      else if (rbeat) acc <= worst(worst(acc, rresp), (rlast != (cnt == len_q)) || rid != ID ? 2'b10 : 2'b00);
      else if (bbeat) acc <= worst(worst(acc, bresp), bid != ID ? 2'b10 : 2'b00);
    end
endmodule

// File: tb/tb_cnn_axi_mst.sv
// tb_cnn_axi_mst: directed and randomized bursts against a slave model with worst-response scoreboard
module tb_cnn_axi_mst;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [31:0] cmd_addr = 0, wd_data = 0, rd_data, araddr, awaddr, rdata = 0, wdata;
  logic [3:0] cmd_len = 0, arlen, awlen, wstrb;
  logic wd_valid = 0, wd_ready, rd_valid, rd_last, done;
  logic [1:0] done_resp, arbrust, awbrust, rresp = 0, bresp = 0, arlock, awlock;
  logic [11:0] arid, awid, wid, rid = 0, bid = 0;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic arvalid, arready = 0, rlast = 0, ruser = 0, rvalid = 0, rready;
  logic awvalid, awready = 0, wlast, wvalid, wready = 0, buser = 0, bvalid = 0, bready;
  logic [3:0] arcache, awcache, arqos, awqos, arregion;
  int n_chk = 0, n_fail = 0, done_cnt = 0, d0;
  logic [1:0] last_resp = 0;
  logic [32:0] rdq[$];

  cnn_axi_mst dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .done(done), .done_resp(done_resp),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arbrust(arbrust), .arvalid(arvalid),
    .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awbrust(awbrust), .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .buser(buser),
    .bvalid(bvalid), .bready(bready), .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos)
  );

  always @(negedge clk) begin
    if (rd_valid) rdq.push_back({rd_last, rd_data});
    if (done) begin done_cnt++; last_resp = done_resp; end
  end

  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return a > b ? a : b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [3:0] l);
    for (int k = 0; k < 20 && !cmd_ready; k++) @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 0;
    chk("cmd_ready_drop", cmd_ready, 0);
  endtask

  task automatic wait_done(input int base, input logic [1:0] exp_resp);
    for (int k = 0; k < 40 && done_cnt == base; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - base, 1);
    chk("done_resp", last_resp, exp_resp);
  endtask

  // err_beat: -1 all OKAY, -2 random OKAY/EXOKAY, otherwise that beat returns SLVERR
  task automatic do_read(input logic [31:0] a, input logic [3:0] l, input int last_at,
                         input int err_beat, input logic id_bad, input logic [31:0] dbase);
    logic [1:0] exp_resp;
    logic [32:0] exq[$];
    int base;
    base = done_cnt;
    exp_resp = 2'b00;
    rdq.delete();
    issue(0, a, l);
    for (int k = 0; k < 20 && !arvalid; k++) @(negedge clk);
    chk("arvalid", arvalid, 1);
    chk("araddr", araddr, a);
    chk("arlen", arlen, l);
    chk("ar_attr", {arsize, arbrust, arid}, {3'd2, 2'b01, 12'd0});
    repeat ($urandom_range(0, 3)) begin @(negedge clk); chk("arvalid_hold", arvalid, 1); end
    arready = 1; @(negedge clk); arready = 0;
    for (int i = 0; i <= last_at; i++) begin
      logic [1:0] rs;
      logic [31:0] d;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rs = i == err_beat ? 2'b10 : err_beat == -2 ? 2'($urandom_range(0, 1)) : 2'b00;
      d = dbase + 32'(i);
      rvalid = 1; rdata = d; rresp = rs; rlast = i == last_at; rid = (id_bad && i == 0) ? 12'h5 : 12'h0;
      chk("rready", rready, 1);
      exp_resp = worst(exp_resp, rs);
      exq.push_back({i == last_at, d});
      @(negedge clk);
      rvalid = 0; rlast = 0; rid = 0; rresp = 0;
    end
    if (last_at != int'(l) || id_bad) exp_resp = worst(exp_resp, 2'b10);
    wait_done(base, exp_resp);
    chk("rd_count", rdq.size(), exq.size());
    for (int i = 0; i < exq.size() && i < rdq.size(); i++) chk("rd_beat", rdq[i], exq[i]);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [3:0] l, input logic gaps,
                          input logic [1:0] bv, input logic id_bad, input logic [31:0] first);
    logic [31:0] wq[$];
    int acc_n, base;
    base = done_cnt;
    acc_n = 0;
    wq.push_back(first);
    for (int i = 1; i <= int'(l); i++) wq.push_back($urandom);
    issue(1, a, l);
    wd_valid = 1; wd_data = wq[0];
    for (int k = 0; k < 20 && !awvalid; k++) @(negedge clk);
    chk("awvalid", awvalid, 1);
    chk("awaddr", awaddr, a);
    chk("awlen", awlen, l);
    chk("aw_attr", {awsize, awbrust, awid, wid}, {3'd2, 2'b01, 12'd0, 12'd0});
    repeat ($urandom_range(0, 3)) begin @(negedge clk); chk("awvalid_hold", awvalid, 1); end
    chk("w_before_aw", wvalid, 0);
    awready = 1; @(negedge clk); awready = 0;
    for (int k = 0; k < 200 && acc_n <= int'(l); k++) begin
      wd_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wready = gaps ? k[0] : 1'b1;
      wd_data = wq[acc_n];
      #1;
      chk("wvalid", wvalid, wd_valid);
      chk("wd_ready", wd_ready, wready);
      if (wvalid && wready) begin
        chk("wdata", wdata, wq[acc_n]);
        chk("wlast", wlast, acc_n == int'(l));
        chk("wstrb", wstrb, 4'hF);
        acc_n++;
      end
      @(negedge clk);
    end
    chk("w_beats", acc_n, int'(l) + 1);
    wd_valid = 1; wready = 1; #1;
    chk("w_after_last", {wvalid, wd_ready}, 0);
    chk("bready", bready, 1);
    wd_valid = 0; wready = 0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bvalid = 1; bresp = bv; bid = id_bad ? 12'h7 : 12'h0;
    @(negedge clk);
    bvalid = 0; bresp = 0; bid = 0;
    wait_done(base, worst(bv, id_bad ? 2'b10 : 2'b00));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", {cmd_ready, arvalid, awvalid, wvalid, rready, bready, rd_valid, rd_last, done, done_resp, wd_ready}, 0);
    chk("rst_addr", {araddr, arlen}, 0);
    chk("rst_rdata", rd_data, 0);
    chk("ax_const", {arlock, arcache, arprot, arqos, arregion, awlock, awcache, awprot, awqos}, 0);
    rst_n = 1;
    @(negedge clk);
    do_read(32'h100, 4'd3, 3, -1, 1'b0, 32'hA0);
    do_write(32'h200, 4'd0, 1'b0, 2'b00, 1'b0, 32'hDEADBEEF);
    do_write(32'h400, 4'd15, 1'b1, 2'b00, 1'b0, $urandom);
    do_read(32'h500, 4'd1, 1, 1, 1'b0, $urandom);
    do_read(32'h600, 4'd3, 0, -1, 1'b0, $urandom);
    do_read(32'h700, 4'd1, 3, -1, 1'b0, $urandom);
    do_read(32'h800, 4'd2, 2, -1, 1'b1, $urandom);
    do_read(32'h900, 4'd15, 15, -2, 1'b0, $urandom);
    do_write(32'hA00, 4'd2, 1'b0, 2'b01, 1'b0, $urandom);
    do_write(32'hB00, 4'd1, 1'b1, 2'b00, 1'b1, $urandom);
    for (int t = 0; t < 8; t++) begin
      logic [3:0] l;
      logic [31:0] a;
      l = 4'($urandom_range(0, 15));
      a = $urandom & 32'h000F_FFFC;
      if ($urandom_range(0, 1) == 1) do_write(a, l, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b0, $urandom);
      else do_read(a, l, int'(l), -2, 1'b0, $urandom);
    end
    issue(1, 32'h300, 4'd7);
    wd_valid = 1; wd_data = 32'h1234;
    for (int k = 0; k < 20 && !awvalid; k++) @(negedge clk);
    awready = 1; @(negedge clk); awready = 0;
    wready = 1; @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("rst_mid_valids", {arvalid, awvalid, wvalid, wd_ready, rready, bready, rd_valid, done, cmd_ready}, 0);
    wd_valid = 0; wready = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_nodone", done_cnt - d0, 0);
    do_read(32'hC00, 4'd2, 2, -1, 1'b0, 32'h55);
`ifdef CNN_AXI_MST_TIMEOUT_EN
    d0 = done_cnt;
    issue(1, 32'hD00, 4'd0);
    for (int k = 0; k < 70000 && done_cnt == d0; k++) @(negedge clk);
    @(negedge clk);
    chk("tmo_done", done_cnt - d0, 1);
    chk("tmo_resp", last_resp, 2'b11);
    chk("tmo_awvalid", awvalid, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cnn_axi_mst.md
Name: cnn_axi_mst

Overview:
- AXI3-style burst initiator that drives the read/write channel set served by the cnn_top slave port.
- Turns a simple command request (one burst, read or write) into AR/R or AW/W/B transactions.
- Write data comes in on a valid/ready stream; read data leaves on one.
- Used by a host-side test harness or a DMA front end to load weights and frames and read back results.

Parameters:
DATA_WIDTH, 32, AXI data width; bytes per beat = DATA_WIDTH/8.
ADDR_WIDTH, 32, AXI address width.
ID_MAX_WIDTH, 12, AXI ID width.
MST_ID, 0, constant ID driven on arid/awid/wid.

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
cmd_valid / cmd_ready  in / out  1 / 1  command handshake
cmd_wr  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_WIDTH  start byte address, beat-aligned
cmd_len  in  4  beats minus 1 (AXI3 arlen/awlen encoding)
wd_data / wd_valid / wd_ready  in / in / out  DATA_WIDTH / 1 / 1  write-data stream
rd_data / rd_valid / rd_last  out  DATA_WIDTH / 1 / 1  read-data stream, no backpressure
done  out  1  one-cycle pulse at end of command
done_resp  out  2  worst response of the burst, valid with done
arid, araddr, arlen, arsize, arbrust, arvalid / arready  AXI AR channel (master side)
rid, rdata, rresp, rlast, ruser, rvalid / rready  AXI R channel
awid, awaddr, awlen, awsize, awbrust, awvalid / awready  AXI AW channel
wid, wdata, wstrb, wlast, wvalid / wready  AXI W channel
bid, bresp, buser, bvalid / bready  AXI B channel
arlock, arcache, arprot, arqos, arregion, awlock, awcache, awprot, awqos  out  per AXI  all constant 0

Behaviour:
- Reset values: all valid outputs 0, cmd_ready 0 (the FSM goes to IDLE and asserts cmd_ready there), done 0, done_resp 0, address/len/data registers 0. Reset mid-burst abandons the burst immediately with no completion pulse.
- Constants:
  - arsize = awsize = log2(DATA_WIDTH/8) (3'b010 at 32 bits).
  - arbrust = awbrust = 2'b01 (INCR).
  - wstrb = all ones.
  - arid = awid = wid = MST_ID.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr/len/wr, clear the error accumulator.
  - Go to RD_ADDR (cmd_wr = 0) or WR_ADDR (cmd_wr = 1).
  - cmd_ready drops the next cycle.
- RD_ADDR: arvalid = 1 with registered araddr/arlen; hold until arready; then go to RD_DATA. arvalid never deasserts before arready.
- RD_DATA:
  - rready = 1 constantly.
  - Each rvalid beat: rd_data = rdata, rd_valid = 1 (one registered cycle later), rd_last = rlast.
  - Accumulate resp = max(acc, rresp).
  - Beat counter increments. Leave on the beat carrying rlast.
  - If rlast arrives early or late versus cmd_len, set acc to 2'b10 (SLVERR); the FSM follows rlast.
- WR_ADDR: awvalid = 1 until awready; then go to WR_DATA. W is never issued before AW completes.
- WR_DATA:
  - wvalid = wd_valid, wdata = wd_data, wd_ready = wready (combinational pass-through, zero-latency).
  - Beat counter counts accepted beats (wvalid & wready). wlast = 1 when count == len.
  - Go to WR_RESP after the last beat.
- WR_RESP: bready = 1; on bvalid, acc = max(acc, bresp); go to DONE.
- DONE:
  - done = 1 for exactly one cycle, with done_resp = acc; return to IDLE.
  - A new command is accepted the following cycle at the earliest.
- Response and ID checks:
  - ruser and buser are ignored.
  - An rid or bid not equal to MST_ID forces acc = 2'b10.
- Boundaries:
  - cmd_len = 0 gives a single beat with wlast on the first beat.
  - cmd_len = 15 gives 16 beats; the counter is 4 bits with no wrap issue.
  - An address crossing 4 KB is not checked (caller's responsibility).

Optional Feature:
- Macro CNN_AXI_MST_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog resets on every handshake and counts cycles in any non-IDLE/DONE state.
  - At 0xFFFF the FSM drops all valids and ready signals and jumps to DONE with done_resp = 2'b11 (DECERR).
- When undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Read, cmd_addr=0x100, len=3; slave returns 0xA0..0xA3 with OKAY → araddr=0x100, arlen=3, four rd_valid pulses in order, rd_last on 0xA3, done with done_resp=00.
- Write, addr=0x200, len=0; wd_data=0xDEADBEEF → awaddr=0x200, awlen=0, one W beat with wlast=1 and wstrb=4'hF; after bresp=00, one done pulse.
- Write, len=15, with wready toggling every other cycle and wd_valid gaps → exactly 16 beats accepted, wlast only on the 16th, no data lost or duplicated.
- Read, len=1, second beat rresp=2'b10 → done_resp=10; early rlast on beat 0 with len=3 → done_resp=10 and return to IDLE.
- Assert rst_n=0 during WR_DATA → all valids 0 asynchronously; after release, cmd_ready=1 and no done pulse.
- With CNN_AXI_MST_TIMEOUT_EN, awready held low → done pulse after 65535 cycles with done_resp=11 and awvalid cleared.
